// File: rtl/lock_pkg.sv
// Shared definitions for the passcode lock: FSM state encoding (identical to
// the o_Status codes) and the counter-width helper.
package lock_pkg;

  localparam int unsigned STATUS_W = 3;

  typedef enum logic [STATUS_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_ENTRY    = 3'd1,
    ST_CHECK    = 3'd2,
    ST_UNLOCKED = 3'd3,
    ST_FAIL     = 3'd4,
    ST_LOCKOUT  = 3'd5,
    ST_PROGRAM  = 3'd6
  } state_e;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that saturates at zero. expired_o is high whenever
// the count is zero, so a load of N-1 expires N cycles after the load edge.
module lock_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Load takes priority; otherwise count down and stick at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/passcode_lock_core.sv
// N-digit passcode lock: digit capture, registered compare, fail-count
// lockout, entry timeout, auto-relock and in-field code programming.
// One shared timer serves the entry timeout, lockout and unlock hold.
module passcode_lock_core
  import lock_pkg::*;
#(
  parameter int unsigned                     NUM_DIGITS     = 4,
  parameter int unsigned                     DIGIT_W        = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0]   DEFAULT_CODE   = 16'h1234,
  parameter int unsigned                     MAX_FAILS      = 3,
  parameter int unsigned                     ENTRY_TIMEOUT  = 25_000_000,
  parameter int unsigned                     LOCKOUT_CYCLES = 250_000_000,
  parameter int unsigned                     UNLOCK_HOLD    = 125_000_000
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic                  i_Digit_Valid,
  input  logic [DIGIT_W-1:0]    i_Digit,
  input  logic                  i_Clear,
  input  logic                  i_Lock,
  input  logic                  i_Prog,
  output logic                  o_Unlocked,
  output logic                  o_Fail,
  output logic                  o_Lockout,
  output logic                  o_Prog_Done,
  output logic [NUM_DIGITS-1:0] o_Digit_LEDs,
  output logic [STATUS_W-1:0]   o_Status
);

  localparam int unsigned CODE_W  = NUM_DIGITS * DIGIT_W;
  localparam int unsigned DCNT_W  = cnt_w(NUM_DIGITS);
  localparam int unsigned FCNT_W  = cnt_w(MAX_FAILS);
  localparam int unsigned TMAX_A  = (ENTRY_TIMEOUT > LOCKOUT_CYCLES) ? ENTRY_TIMEOUT : LOCKOUT_CYCLES;
  localparam int unsigned TMR_MAX = (TMAX_A > UNLOCK_HOLD) ? TMAX_A : UNLOCK_HOLD;
  localparam int unsigned TMR_W   = cnt_w(TMR_MAX);

  // Timer loads are N-1 so each interval lasts exactly N cycles.
  localparam logic [TMR_W-1:0] T_ENTRY = TMR_W'(ENTRY_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] T_LOCK  = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] T_HOLD  = TMR_W'(UNLOCK_HOLD - 1);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   shift_q, shift_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic [FCNT_W-1:0]   fail_q, fail_d;
  logic                match_q;
  logic                dcnt_full;
  logic                digit_take;
  logic                prog_commit;
  logic                state_change;
  logic                tmr_load;
  logic [TMR_W-1:0]    tmr_val;
  logic                tmr_expired;

  assign dcnt_full    = (dcnt_q == DCNT_W'(NUM_DIGITS));
  assign digit_take   = i_Digit_Valid && !i_Clear && !dcnt_full &&
                        (state_q inside {ST_IDLE, ST_ENTRY, ST_PROGRAM});
  assign prog_commit  = (state_q == ST_PROGRAM) && dcnt_full && !i_Clear;
  assign state_change = (state_d != state_q);

  lock_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk_i      (i_Clk),
    .rst_ni     (i_Rst_L),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  // FSM state register.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic. A strobe in the same cycle as timer expiry counts as
  // activity, so the timeout only fires on a genuinely idle cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (digit_take) state_d = ST_ENTRY;
      ST_ENTRY: begin
        if (i_Clear)                            state_d = ST_IDLE;
        else if (dcnt_full)                     state_d = ST_CHECK;
        else if (tmr_expired && !i_Digit_Valid) state_d = ST_IDLE;
      end
      ST_CHECK:    state_d = match_q ? ST_UNLOCKED : ST_FAIL;
      ST_FAIL:     state_d = (fail_q >= FCNT_W'(MAX_FAILS)) ? ST_LOCKOUT : ST_IDLE;
      ST_LOCKOUT:  if (tmr_expired) state_d = ST_IDLE;
      ST_UNLOCKED: begin
        if (i_Lock)           state_d = ST_IDLE;
        else if (i_Prog)      state_d = ST_PROGRAM;
        else if (tmr_expired) state_d = ST_IDLE;
      end
      ST_PROGRAM: begin
        if (i_Clear || dcnt_full)               state_d = ST_UNLOCKED;
        else if (tmr_expired && !i_Digit_Valid) state_d = ST_UNLOCKED;
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  // Datapath next values and timer control. A state change wipes the partial
  // entry first; the IDLE->ENTRY strobe is then shifted into the empty word.
  always_comb begin
    shift_d  = shift_q;
    dcnt_d   = dcnt_q;
    fail_d   = fail_q;
    code_d   = code_q;
    tmr_load = 1'b0;
    tmr_val  = T_ENTRY;

    if (state_change) begin
      shift_d = '0;
      dcnt_d  = '0;
    end
    if (digit_take) begin
      shift_d  = (shift_d << DIGIT_W) | CODE_W'(i_Digit);
      dcnt_d   = dcnt_d + 1'b1;
      tmr_load = 1'b1;
      tmr_val  = T_ENTRY;
    end

    if (state_change) begin
      unique case (state_d)
        ST_UNLOCKED: begin tmr_load = 1'b1; tmr_val = T_HOLD;  end
        ST_LOCKOUT:  begin tmr_load = 1'b1; tmr_val = T_LOCK;  end
        ST_PROGRAM:  begin tmr_load = 1'b1; tmr_val = T_ENTRY; end
        default: ;
      endcase
    end

    if (state_q == ST_CHECK) begin
      fail_d = match_q ? '0 : fail_q + 1'b1;
    end
    if ((state_q == ST_LOCKOUT) && (state_d == ST_IDLE)) begin
      fail_d = '0;
    end
    if (prog_commit) begin
      code_d = shift_q;
    end
  end

  // Datapath registers; the compare is registered so CHECK sees a clean verdict.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      shift_q <= '0;
      dcnt_q  <= '0;
      fail_q  <= '0;
      code_q  <= DEFAULT_CODE;
      match_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      dcnt_q  <= dcnt_d;
      fail_q  <= fail_d;
      code_q  <= code_d;
      match_q <= (shift_q == code_q);
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    o_Unlocked   = (state_q == ST_UNLOCKED);
    o_Fail       = (state_q == ST_FAIL);
    o_Lockout    = (state_q == ST_LOCKOUT);
    o_Prog_Done  = prog_commit;
    o_Status     = state_q;
    o_Digit_LEDs = '0;
    if (state_q inside {ST_ENTRY, ST_PROGRAM}) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        o_Digit_LEDs[k] = (32'(dcnt_q) > k);
      end
    end
  end

endmodule
